id_ex_stage: RTL and testbench

ID/EX pipeline stage for the five-stage MIPS pipeline: registers decoded instruction, operands and destination info, and presents them to the ALU as `ex_instr`, `ex_reg_a`, `ex_reg_b`. Resolves operand RAW hazards by forwarding from the EX/MEM and MEM/WB stages, raises a load-use stall toward decode, and inserts bubbles on stall or branch flush. It also keeps a saturating bubble counter for performance inspection.

---
 rtl/id_ex_stage.sv | 174 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register for the five-stage MIPS pipeline.
//
// Holds the decoded instruction, its operands and its destination info, and
// presents them to the ALU. Resolves operand RAW hazards by bypassing from
// EX/MEM and MEM/WB, raises a stall toward decode, and turns the stage into a
// bubble on stall or branch flush. A saturating counter tracks stall bubbles.
//
// Build option:
//   ID_EX_FWD_EN defined   -> bypass muxes active; stall only on load-use.
//   ID_EX_FWD_EN undefined -> operands come straight from the stage regs;
//                             stall on any RAW hit against EX or EX/MEM.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   id_valid/instr/reg_a/reg_b       decode slot contents
//   id_src_a/src_b                   operand source regs (0 = no register read)
//   id_dst/wen/is_load               destination info of decode slot
//   flush                            kill the instruction entering EX
//   exm_wen/dst/result               EX/MEM producer bypass bus
//   wb_wen/dst/data                  MEM/WB producer bypass bus
//   ex_valid/instr/dst/wen/is_load   registered stage contents
//   ex_reg_a/reg_b                   operands to ALU (after bypass)
//   id_stall                         hold decode/PC this cycle
//   bubble_cnt                       saturating count of stall bubbles
module id_ex_stage #(
  parameter int BUB_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [31:0]      id_instr,
  input  logic [31:0]      id_reg_a,
  input  logic [31:0]      id_reg_b,
  input  logic [4:0]       id_src_a,
  input  logic [4:0]       id_src_b,
  input  logic [4:0]       id_dst,
  input  logic             id_wen,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             exm_wen,
  input  logic [4:0]       exm_dst,
  input  logic [31:0]      exm_result,
  input  logic             wb_wen,
  input  logic [4:0]       wb_dst,
  input  logic [31:0]      wb_data,
  output logic             ex_valid,
  output logic [31:0]      ex_instr,
  output logic [4:0]       ex_dst,
  output logic             ex_wen,
  output logic             ex_is_load,
  output logic [31:0]      ex_reg_a,
  output logic [31:0]      ex_reg_b,
  output logic             id_stall,
  output logic [BUB_W-1:0] bubble_cnt
);

  logic             valid_q, valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      reg_a_q, reg_a_d;
  logic [31:0]      reg_b_q, reg_b_d;
  logic [4:0]       src_a_q, src_a_d;
  logic [4:0]       src_b_q, src_b_d;
  logic [4:0]       dst_q, dst_d;
  logic             wen_q, wen_d;
  logic             is_load_q, is_load_d;
  logic [BUB_W-1:0] bub_q, bub_d;

  logic             hazard;

  // True when either decode operand reads register d (register 0 never counts).
  function automatic logic raw_hit(input logic [4:0] d, input logic [4:0] sa,
                                   input logic [4:0] sb);
    raw_hit = (d != 5'd0) && ((sa == d) || (sb == d));
  endfunction

`ifdef ID_EX_FWD_EN
  // Youngest producer wins: EX/MEM before MEM/WB.
  function automatic logic [31:0] bypass(input logic [4:0] src, input logic [31:0] lat,
                                         input logic xw, input logic [4:0] xd,
                                         input logic [31:0] xr, input logic ww,
                                         input logic [4:0] wd, input logic [31:0] wr);
    if (src == 5'd0)              bypass = lat;
    else if (xw && (xd == src))   bypass = xr;
    else if (ww && (wd == src))   bypass = wr;
    else                          bypass = lat;
  endfunction

  always_comb begin
    ex_reg_a = bypass(src_a_q, reg_a_q, exm_wen, exm_dst, exm_result, wb_wen, wb_dst, wb_data);
    ex_reg_b = bypass(src_b_q, reg_b_q, exm_wen, exm_dst, exm_result, wb_wen, wb_dst, wb_data);
    // Only a load in EX cannot be bypassed in time: its data exists after MEM.
    hazard   = valid_q && is_load_q && wen_q && raw_hit(dst_q, id_src_a, id_src_b);
  end
`else
  logic unused_bypass;
  assign unused_bypass = ^{exm_result, wb_wen, wb_dst, wb_data, src_a_q, src_b_q};

  always_comb begin
    ex_reg_a = reg_a_q;
    ex_reg_b = reg_b_q;
    // No bypass: wait until the producer has left EX/MEM. MEM/WB is covered by
    // the write-first register file.
    hazard   = (valid_q && wen_q && raw_hit(dst_q, id_src_a, id_src_b)) ||
               (exm_wen && raw_hit(exm_dst, id_src_a, id_src_b));
  end
`endif

  // Flush outranks the stall: the decode slot is being killed anyway.
  assign id_stall = id_valid && !flush && hazard;

  always_comb begin
    valid_d   = valid_q;
    instr_d   = instr_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    src_a_d   = src_a_q;
    src_b_d   = src_b_q;
    dst_d     = dst_q;
    wen_d     = wen_q;
    is_load_d = is_load_q;
    bub_d     = bub_q;
    if (flush || id_stall) begin
      valid_d   = 1'b0;
      wen_d     = 1'b0;
      is_load_d = 1'b0;
      if (id_stall && (bub_q != {BUB_W{1'b1}}))
        bub_d = bub_q + 1'b1;
    end else begin
      valid_d   = id_valid;
      instr_d   = id_instr;
      reg_a_d   = id_reg_a;
      reg_b_d   = id_reg_b;
      src_a_d   = id_src_a;
      src_b_d   = id_src_b;
      dst_d     = id_dst;
      wen_d     = id_wen && id_valid;
      is_load_d = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      instr_q   <= '0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      src_a_q   <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      wen_q     <= 1'b0;
      is_load_q <= 1'b0;
      bub_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      instr_q   <= instr_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      src_a_q   <= src_a_d;
      src_b_q   <= src_b_d;
      dst_q     <= dst_d;
      wen_q     <= wen_d;
      is_load_q <= is_load_d;
      bub_q     <= bub_d;
    end
  end

  assign ex_valid   = valid_q;
  assign ex_instr   = instr_q;
  assign ex_dst     = dst_q;
  assign ex_wen     = wen_q && valid_q;
  assign ex_is_load = is_load_q;
  assign bubble_cnt = bub_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage. Small counter width so saturation is
// reachable. Expected stage contents are pushed to a queue as each cycle is
// driven and popped/compared after the clock edge.
module tb_id_ex_stage;
  localparam int BW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          id_valid, id_wen, id_is_load, flush;
  logic [31:0]   id_instr, id_reg_a, id_reg_b;
  logic [4:0]    id_src_a, id_src_b, id_dst;
  logic          exm_wen, wb_wen;
  logic [4:0]    exm_dst, wb_dst;
  logic [31:0]   exm_result, wb_data;
  logic          ex_valid, ex_wen, ex_is_load, id_stall;
  logic [31:0]   ex_instr, ex_reg_a, ex_reg_b;
  logic [4:0]    ex_dst;
  logic [BW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          v;
    logic [31:0]   instr;
    logic [4:0]    dst;
    logic          wen;
    logic          ld;
    logic [BW-1:0] bub;
  } exp_t;

  exp_t q[$];
  exp_t m;

  id_ex_stage #(.BUB_W(BW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_reg_a(id_reg_a), .id_reg_b(id_reg_b), .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_dst(id_dst), .id_wen(id_wen), .id_is_load(id_is_load), .flush(flush),
    .exm_wen(exm_wen), .exm_dst(exm_dst), .exm_result(exm_result),
    .wb_wen(wb_wen), .wb_dst(wb_dst), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_dst(ex_dst), .ex_wen(ex_wen),
    .ex_is_load(ex_is_load), .ex_reg_a(ex_reg_a), .ex_reg_b(ex_reg_b),
    .id_stall(id_stall), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] a,
                     input logic [31:0] b, input logic [4:0] sa, input logic [4:0] sb,
                     input logic [4:0] d, input logic w, input logic ld);
    id_valid = v; id_instr = ins; id_reg_a = a; id_reg_b = b;
    id_src_a = sa; id_src_b = sb; id_dst = d; id_wen = w; id_is_load = ld;
  endtask

  // One clock: check the stall decision, predict the stage after the edge,
  // clock, then compare.
  task automatic cyc(input logic exp_stall, input string tag);
    exp_t e;
    exp_t got;
    #1;
    chk({tag, ".stall"}, {31'd0, id_stall}, {31'd0, exp_stall});
    e = m;
    if (flush || exp_stall) begin
      e.v = 1'b0; e.wen = 1'b0; e.ld = 1'b0;
      if (!flush && e.bub != {BW{1'b1}}) e.bub = e.bub + 1'b1;
    end else begin
      e.v = id_valid; e.instr = id_instr; e.dst = id_dst;
      e.wen = id_wen & id_valid; e.ld = id_is_load;
    end
    q.push_back(e);
    m = e;
    @(posedge clk);
    #1;
    got = q.pop_front();
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, got.v});
    chk({tag, ".wen"}, {31'd0, ex_wen}, {31'd0, got.wen});
    chk({tag, ".bub"}, {{(32-BW){1'b0}}, bubble_cnt}, {{(32-BW){1'b0}}, got.bub});
    if (got.v) begin
      chk({tag, ".instr"}, ex_instr, got.instr);
      chk({tag, ".dst"}, {27'd0, ex_dst}, {27'd0, got.dst});
      chk({tag, ".load"}, {31'd0, ex_is_load}, {31'd0, got.ld});
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, ".wen"}, {31'd0, ex_wen}, 32'd0);
    chk({tag, ".instr"}, ex_instr, 32'd0);
    chk({tag, ".bub"}, {{(32-BW){1'b0}}, bubble_cnt}, 32'd0);
    chk({tag, ".stall"}, {31'd0, id_stall}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    exm_wen = 0; exm_dst = 0; exm_result = 0;
    wb_wen = 0; wb_dst = 0; wb_data = 0;
    m = '0;
    #3;
    chk_reset("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Plain capture, no bypass active.
    drv(1, 32'h1111_0001, 32'h10, 32'h20, 1, 2, 3, 1, 0);
    cyc(0, "cap");
    chk("cap.a", ex_reg_a, 32'h10);
    chk("cap.b", ex_reg_b, 32'h20);

`ifdef ID_EX_FWD_EN
    // ALU result bypass; EX/MEM beats MEM/WB.
    drv(1, 32'h2222_0002, 32'h0, 32'h77, 3, 0, 7, 1, 0);
    exm_wen = 1; exm_dst = 3; exm_result = 32'h5;
    cyc(0, "raw");
    wb_wen = 1; wb_dst = 3; wb_data = 32'h9;
    #1 chk("fwd.exm_prio", ex_reg_a, 32'h5);
    chk("fwd.b_src0", ex_reg_b, 32'h77);
    exm_wen = 0;
    #1 chk("fwd.wb", ex_reg_a, 32'h9);
    wb_wen = 0;
    #1 chk("fwd.none", ex_reg_a, 32'h0);
`else
    // Non-load producer: two stall cycles (in EX, then in EX/MEM).
    drv(1, 32'h5555_0005, 32'h1, 32'h2, 0, 0, 5, 1, 0);
    cyc(0, "add5");
    drv(1, 32'h2222_0002, 32'h0, 32'h77, 5, 0, 7, 1, 0);
    cyc(1, "nf_ex");
    exm_wen = 1; exm_dst = 5; exm_result = 32'h5;
    cyc(1, "nf_exm");
    exm_wen = 0;
    cyc(0, "nf_go");
    chk("nf.bub2", {{(32-BW){1'b0}}, bubble_cnt}, 32'd2);
    id_valid = 0;
    exm_wen = 1; wb_wen = 1; wb_dst = 5; wb_data = 32'h9;
    #1 chk("nf.latched_a", ex_reg_a, 32'h0);
    chk("nf.no_stall_idle", {31'd0, id_stall}, 32'd0);
    exm_wen = 0; wb_wen = 0;
`endif

    // src 0 is never bypassed even when EX/MEM writes register 0.
    drv(1, 32'h3333_0003, 32'h0, 32'h7, 0, 0, 8, 1, 0);
    exm_wen = 1; exm_dst = 0; exm_result = 32'hdead_beef;
    cyc(0, "src0");
    chk("src0.b", ex_reg_b, 32'h7);
    chk("src0.a", ex_reg_a, 32'h0);
    exm_wen = 0;

    // Load-use: one bubble, then the consumer picks up load data from MEM/WB.
    drv(1, 32'h8c04_0000, 0, 0, 0, 0, 4, 1, 1);
    cyc(0, "lw4");
    drv(1, 32'h4444_0004, 32'h0, 32'h11, 0, 4, 9, 1, 0);
    cyc(1, "lu");
`ifndef ID_EX_FWD_EN
    exm_wen = 1; exm_dst = 4;
    cyc(1, "lu_exm");
    exm_wen = 0;
`endif
    cyc(0, "lu_go");
    wb_wen = 1; wb_dst = 4; wb_data = 32'habcd;
`ifdef ID_EX_FWD_EN
    #1 chk("lu.wb_fwd", ex_reg_b, 32'habcd);
`else
    #1 chk("lu.latched", ex_reg_b, 32'h11);
`endif
    wb_wen = 0;

    // Flush coincident with load-use: no stall, no bubble counted.
    drv(1, 32'h8c06_0000, 0, 0, 0, 0, 6, 1, 1);
    cyc(0, "lw6");
    drv(1, 32'h6666_0006, 0, 0, 6, 0, 10, 1, 0);
    flush = 1;
    cyc(0, "flush");
    flush = 0;

    // Repeated load-use pairs drive the counter into saturation.
    for (int i = 0; i < 8; i++) begin
      drv(1, 32'h8c07_0000 + i, 0, 0, 0, 0, 7, 1, 1);
      cyc(0, "sat_lw");
      drv(1, 32'h7777_0007, 0, 0, 7, 0, 11, 1, 0);
      cyc(1, "sat_lu");
    end
    chk("sat.max", {{(32-BW){1'b0}}, bubble_cnt}, 32'd7);

    // Asynchronous reset mid-cycle, then capture on the first edge after release.
    drv(1, 32'h9999_0009, 0, 0, 0, 0, 12, 1, 0);
    cyc(0, "pre_rst");
    #2 rst_n = 1'b0;
    #1 chk_reset("rst2");
    m = '0;
    q.delete();
    @(negedge clk) rst_n = 1'b1;
    drv(1, 32'haaaa_000a, 32'h3, 32'h4, 0, 0, 13, 1, 0);
    cyc(0, "post_rst");
    chk("post_rst.a", ex_reg_a, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
